if_id_pipe_stage: RTL
=====================

Name: if_id_pipe_stage

Overview:
- Parametrised IF/ID pipeline stage, next generation of the fetch-to-decode register.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush (bubble insertion) and a saturating stall counter.
- Sits between the fetch unit (upstream, producer) and the decode unit (downstream, consumer).
- Allows fetch to run ahead while decode stalls, and lets branch resolution squash in-flight instructions.

Parameters:
- INSTR_WIDTH, 32: instruction word width.
- PC_WIDTH, 32: program counter width.
- NOP_VALUE, {INSTR_WIDTH{1'b0}}: instruction word loaded on reset or flush.
- SKID_ENABLE, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_WIDTH, 16: width of the stall counter.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous squash of all held entries.
- in_valid, input, 1: fetch presents an instruction.
- in_ready, output, 1: stage accepts an instruction this cycle.
- instruction_in, input, INSTR_WIDTH: fetched instruction.
- pc_in, input, PC_WIDTH: PC of the fetched instruction.
- out_valid, output, 1: instruction_out/pc_out hold a live instruction.
- out_ready, input, 1: decode consumes this cycle.
- instruction_out, output, INSTR_WIDTH: instruction to decode.
- pc_out, output, PC_WIDTH: PC to decode.
- stall_count, output, CNT_WIDTH: cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- Reset (reset=0, asynchronous, any time including mid-transfer):
  - out_valid=0, instruction_out=NOP_VALUE, pc_out=0.
  - Skid entry invalidated; stall_count=0.
  - in_ready=1 in both modes, because the stage is empty.
- Latency and throughput:
  - Push in cycle N gives out_valid=1 with that data in cycle N+1.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
- SKID_ENABLE=1 state machine (states EMPTY, ONE, FULL):
  - EMPTY: push -> ONE, main<=in.
  - ONE:
    - push & pop -> ONE, main<=in.
    - push & !pop -> FULL, skid<=in, main unchanged.
    - !push & pop -> EMPTY, main data held.
    - Otherwise hold.
  - FULL: pop -> ONE, main<=skid; otherwise hold. No push is possible in FULL.
  - in_ready = (state != FULL). It is a register decode; there is no combinational path from out_ready to in_ready.
  - out_valid = (state != EMPTY).
- SKID_ENABLE=0 (single entry):
  - in_ready = out_ready | !out_valid (combinational).
  - push loads main and sets out_valid.
  - pop without push clears out_valid.
- Data when out_valid=0: instruction_out/pc_out keep their last value, except after reset or flush, where they are NOP_VALUE/0.
- Ordering: strict FIFO order; an instruction is never duplicated or dropped except by flush or reset.
- Flush (sampled at the rising edge, highest priority):
  - Next state is EMPTY; out_valid=0, instruction_out=NOP_VALUE, pc_out=0; skid discarded.
  - A push in the flush cycle is discarded, not stored.
  - A pop in the flush cycle completes normally for the consumer; the entry is then removed.
  - in_ready returns to 1 the cycle after flush.
  - stall_count is unaffected by flush.
- stall_count:
  - Increments by 1 on every cycle where out_valid=1 and out_ready=0.
  - Holds at 2^CNT_WIDTH-1, with no wrap.
  - Cleared only by reset.
- Inputs are ignored when in_ready=0.
- in_valid may drop without a transfer; no upstream stability is required.

Test Plan:
- Reset: assert reset=0 mid-stream with the stage FULL -> immediately out_valid=0, instruction_out=0, pc_out=0, in_ready=1, stall_count=0.
- Streaming: out_ready=1; push (0x20080001, PC 0x0), (0x20090002, PC 0x4), (0x012A5020, PC 0x8) in consecutive cycles -> each appears one cycle later, back-to-back, out_valid=1 for 3 cycles.
- Backpressure (SKID_ENABLE=1): out_ready=0, push A then B -> state FULL and in_ready=0; C is held upstream. Then out_ready=1 -> outputs A, B, C in order with no loss; stall_count equals the stalled cycles.
- Flush: in FULL, assert flush with in_valid=1 and D present -> next cycle out_valid=0, instruction_out=NOP_VALUE, pc_out=0, in_ready=1; D never appears at the output.
- Saturation: CNT_WIDTH=3, out_valid=1, out_ready=0 for 10 cycles -> stall_count reaches 7 and stays 7.
- SKID_ENABLE=0: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> replacement each cycle at full throughput.

Source files
------------

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline stage: valid/ready handshake between fetch and decode,
// optional 2-entry skid buffer, synchronous flush and a saturating stall counter.
module if_id_pipe_stage #(
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     PC_WIDTH    = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_VALUE   = {INSTR_WIDTH{1'b0}},
  parameter bit                     SKID_ENABLE = 1'b1,
  parameter int                     CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] instruction_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [CNT_WIDTH-1:0]   stall_count
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [INSTR_WIDTH-1:0] r_main_instr;
  logic [PC_WIDTH-1:0]    r_main_pc;
  logic [INSTR_WIDTH-1:0] r_skid_instr;
  logic [PC_WIDTH-1:0]    r_skid_pc;
  logic [CNT_WIDTH-1:0]   r_stall;

  logic w_push;
  logic w_pop;
  logic w_clear;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;

  assign out_valid       = (r_state != S_EMPTY);
  assign instruction_out = r_main_instr;
  assign pc_out          = r_main_pc;
  assign stall_count     = r_stall;
  assign w_push          = in_valid & in_ready;
  assign w_pop           = out_valid & out_ready;

  // With the skid buffer in_ready is a pure state decode, so out_ready never
  // reaches fetch combinationally; without it, a pop frees the single slot.
  // FULL is unreachable in single-entry mode because in_ready drops first.
  if (SKID_ENABLE) begin : g_skid
    assign in_ready = (r_state != S_FULL);
  end else begin : g_single
    assign in_ready = out_ready | (r_state == S_EMPTY);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next state and datapath load selects; flush overrides everything
  always_comb begin
    w_state_nxt    = r_state;
    w_clear        = 1'b0;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            w_state_nxt  = S_ONE;
            w_ld_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            w_ld_main_in = 1'b1;
          end else if (w_push) begin
            w_state_nxt = S_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            w_state_nxt    = S_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Main (output) and skid data registers; main keeps its value when emptied
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_instr <= NOP_VALUE;
      r_main_pc    <= '0;
      r_skid_instr <= NOP_VALUE;
      r_skid_pc    <= '0;
    end else begin
      if (w_clear) begin
        r_main_instr <= NOP_VALUE;
        r_main_pc    <= '0;
      end else if (w_ld_main_in) begin
        r_main_instr <= instruction_in;
        r_main_pc    <= pc_in;
      end else if (w_ld_main_skid) begin
        r_main_instr <= r_skid_instr;
        r_main_pc    <= r_skid_pc;
      end
      if (w_ld_skid) begin
        r_skid_instr <= instruction_in;
        r_skid_pc    <= pc_in;
      end
    end
  end

  // Saturating stall counter; only reset clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall <= '0;
    else if (out_valid && !out_ready && !(&r_stall))
      r_stall <= r_stall + CNT_WIDTH'(1);
  end

endmodule
